axis_stream_checker: RTL and testbench
======================================

AXIS_STREAM_CHECKER -- requirements
Module: axis_stream_checker

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the data width of both streams.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the per-input skew FIFO depth; power of two, minimum 2.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the width of every statistics counter.
REQ-004 The block SHALL have port clk  in  1  sole clock; all logic on the rising edge.
REQ-005 The block SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port clear  in  1  synchronous re-arm, same effect as reset.
REQ-007 The block SHALL have port mask  in  DATA_W  compare mask; a bit set to 1 means the bit is compared.
REQ-008 The block SHALL have ports in1_data/in2_data  in  DATA_W  stream payloads.
REQ-009 The block SHALL have ports in1_valid/in2_valid and in1_last/in2_last  in  1  stream valid and frame end.
REQ-010 The block SHALL have ports in1_ready/in2_ready  out  1  stream ready.
REQ-011 The block SHALL have port equal  out  1  sticky all-compared-beats-matched flag.
REQ-012 The block SHALL have port mismatch_count  out  CNT_W  number of mismatching beat pairs, saturating.
REQ-013 The block SHALL have port beat_count  out  CNT_W  number of compared beat pairs, wrapping.
REQ-014 The block SHALL have port first_mismatch_valid  out  1  asserted once a mismatch has been captured.
REQ-015 The block SHALL have port first_mismatch_idx  out  CNT_W  beat index of the first mismatch.
REQ-016 The block SHALL have port frame_done  out  1  one-cycle pulse on a compared frame end.

Function
REQ-017 Each input SHALL have an independent FIFO of DEPTH entries holding {data, last}.
REQ-018 inN_ready SHALL equal not-full of FIFO N, registered-state only; there is no combinational path from the outputs back to ready.
REQ-019 A push SHALL occur on inN_valid & inN_ready; a full FIFO SHALL NOT accept in the cycle it pops.
REQ-020 A compare SHALL fire in any cycle where both FIFOs are non-empty; it SHALL pop both heads in that same cycle.
REQ-021 A pair SHALL match iff ((d1 ^ d2) & mask) == 0 and last1 == last2.
REQ-022 All results SHALL be registered at the edge ending the compare cycle.
REQ-023 A pair pushed into empty FIFOs at edge E SHALL be compared in the next cycle, with results visible after edge E+1.
REQ-024 beat_count SHALL increment by 1 per compare and wrap from all-ones to 0.
REQ-025 mismatch_count SHALL increment per mismatch and saturate at all-ones.
REQ-026 equal SHALL clear to 0 on any mismatch and stay 0 until reset or clear.
REQ-027 On the first mismatch, first_mismatch_idx SHALL capture the pre-increment beat_count and first_mismatch_valid SHALL set to 1.
REQ-028 first_mismatch_idx and first_mismatch_valid SHALL NOT change on later mismatches.
REQ-029 frame_done SHALL pulse for exactly one cycle after a compare in which last1 or last2 is 1.
REQ-030 Counters and the first-mismatch capture SHALL NOT reset at frame boundaries.
REQ-031 With no compare in a cycle, all statistics SHALL hold.
REQ-032 Sustained throughput SHALL be one compare per cycle when both inputs stream continuously.
REQ-033 Input skew of up to DEPTH beats SHALL be absorbed without stalling the leading input.
REQ-034 When clear is asserted, it SHALL flush both FIFOs and set statistics to their reset values at the next edge.
REQ-035 A compare or push coinciding with clear SHALL be discarded.
REQ-036 Both readies SHALL be 0 during the clear cycle.

Reset
REQ-037 While reset is 1, the FIFOs SHALL be empty and in1_ready=in2_ready=0.
REQ-038 Reset SHALL force equal=1, mismatch_count=0, beat_count=0, first_mismatch_valid=0, first_mismatch_idx=0 and frame_done=0.
REQ-039 Readies SHALL rise in the first cycle after reset deasserts.
REQ-040 Reset asserted mid-stream SHALL discard all buffered beats immediately, independent of clk.

Verification
REQ-041 V1 identical streams: 8 beats each, data 0..7, last on beat 7, mask all-ones -> beat_count=8, mismatch_count=0, equal=1, one frame_done pulse.
REQ-042 V2 single mismatch: beat 3 = 0x00 vs 0xFF, mask all-ones -> equal=0, mismatch_count=1, first_mismatch_idx=3; a later mismatch at beat 6 -> mismatch_count=2, idx stays 3.
REQ-043 V3 masking and last: 0x12345678 vs 0x12345600 with mask 0xFFFFFF00 -> match; equal data with last1=1 and last2=0 -> mismatch and frame_done pulse.
REQ-044 V4 skew/backpressure: in1 sends 4 beats before in2 starts (DEPTH=4) -> in1_ready=0 after the 4th beat, all pairs compared in order, no loss; continuous streams -> one compare per cycle.
REQ-045 V5 saturation/wrap: CNT_W=4, 20 mismatching beats -> mismatch_count=15, beat_count=4.
REQ-046 V6 clear and reset: clear mid-stream with a compare pending -> that compare is dropped and stats equal reset values; async reset between edges -> readies drop without a clock edge.

Source files
------------

// File: rtl/axis_stream_checker.sv
// axis_stream_checker: compares two AXI-Stream inputs beat by beat
// through per-input skew FIFOs and keeps running match statistics.
module axis_stream_checker #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [DATA_W-1:0] mask,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_valid,
  input  logic              in1_last,
  output logic              in1_ready,
  input  logic [DATA_W-1:0] in2_data,
  input  logic              in2_valid,
  input  logic              in2_last,
  output logic              in2_ready,
  output logic              equal,
  output logic [CNT_W-1:0]  mismatch_count,
  output logic [CNT_W-1:0]  beat_count,
  output logic              first_mismatch_valid,
  output logic [CNT_W-1:0]  first_mismatch_idx,
  output logic              frame_done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DATA_W:0] mem1 [DEPTH];
  logic [DATA_W:0] mem2 [DEPTH];

  logic [AW:0] wp1, rp1, wp2, rp2;
  logic full1, full2, empty1, empty2;
  logic push1, push2, cmp;
  logic [DATA_W-1:0] h1_data, h2_data;
  logic h1_last, h2_last, mism;

  assign empty1 = (wp1 == rp1);
  assign empty2 = (wp2 == rp2);
  assign full1  = (wp1[AW] != rp1[AW]) &&
                  (wp1[AW-1:0] == rp1[AW-1:0]);
  assign full2  = (wp2[AW] != rp2[AW]) &&
                  (wp2[AW-1:0] == rp2[AW-1:0]);

  // Ready depends only on occupancy and the reset/clear inputs,
  // never on the compare path, so a full FIFO stalls even while popping.
  assign in1_ready = ~full1 & ~reset & ~clear;
  assign in2_ready = ~full2 & ~reset & ~clear;

  assign push1 = in1_valid & in1_ready;
  assign push2 = in2_valid & in2_ready;
  assign cmp   = ~empty1 & ~empty2 & ~clear;

  assign {h1_data, h1_last} = mem1[rp1[AW-1:0]];
  assign {h2_data, h2_last} = mem2[rp2[AW-1:0]];

  assign mism = (((h1_data ^ h2_data) & mask) != '0) ||
                (h1_last != h2_last);

  // Payload storage; occupancy is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (push1) mem1[wp1[AW-1:0]] <= {in1_data, in1_last};
    if (push2) mem2[wp2[AW-1:0]] <= {in2_data, in2_last};
  end

  // FIFO pointers: flushed by reset or clear, else push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp1 <= '0;
      rp1 <= '0;
      wp2 <= '0;
      rp2 <= '0;
    end else if (clear) begin
      wp1 <= '0;
      rp1 <= '0;
      wp2 <= '0;
      rp2 <= '0;
    end else begin
      if (push1) wp1 <= wp1 + PTR_ONE;
      if (push2) wp2 <= wp2 + PTR_ONE;
      if (cmp) begin
        rp1 <= rp1 + PTR_ONE;
        rp2 <= rp2 + PTR_ONE;
      end
    end
  end

  // Statistics update on each compared head pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      equal                <= 1'b1;
      mismatch_count       <= '0;
      beat_count           <= '0;
      first_mismatch_valid <= 1'b0;
      first_mismatch_idx   <= '0;
      frame_done           <= 1'b0;
    end else if (clear) begin
      equal                <= 1'b1;
      mismatch_count       <= '0;
      beat_count           <= '0;
      first_mismatch_valid <= 1'b0;
      first_mismatch_idx   <= '0;
      frame_done           <= 1'b0;
    end else begin
      frame_done <= cmp & (h1_last | h2_last);
      if (cmp) begin
        beat_count <= beat_count + CNT_ONE;
        if (mism) begin
          equal <= 1'b0;
          if (mismatch_count != '1)
            mismatch_count <= mismatch_count + CNT_ONE;
          if (!first_mismatch_valid) begin
            first_mismatch_valid <= 1'b1;
            first_mismatch_idx   <= beat_count;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_stream_checker.sv
// tb_axis_stream_checker: randomized and directed checks of the
// stream checker against a queue-based reference model.
module tb_axis_stream_checker;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset, clear;
  logic [DW-1:0] mask, in1_data, in2_data;
  logic          in1_valid, in1_last, in2_valid, in2_last;

  logic          in1_ready, in2_ready, equal, first_mismatch_valid;
  logic          frame_done;
  logic [15:0]   mismatch_count, beat_count, first_mismatch_idx;

  logic          d4_in1_ready, d4_in2_ready, d4_equal, d4_fmv, d4_fd;
  logic [3:0]    d4_mis, d4_beat, d4_fidx;

  always #5 clk = ~clk;

  axis_stream_checker #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .clear(clear), .mask(mask),
    .in1_data(in1_data), .in1_valid(in1_valid),
    .in1_last(in1_last), .in1_ready(in1_ready),
    .in2_data(in2_data), .in2_valid(in2_valid),
    .in2_last(in2_last), .in2_ready(in2_ready),
    .equal(equal), .mismatch_count(mismatch_count),
    .beat_count(beat_count),
    .first_mismatch_valid(first_mismatch_valid),
    .first_mismatch_idx(first_mismatch_idx),
    .frame_done(frame_done)
  );

  axis_stream_checker #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .clear(clear), .mask(mask),
    .in1_data(in1_data), .in1_valid(in1_valid),
    .in1_last(in1_last), .in1_ready(d4_in1_ready),
    .in2_data(in2_data), .in2_valid(in2_valid),
    .in2_last(in2_last), .in2_ready(d4_in2_ready),
    .equal(d4_equal), .mismatch_count(d4_mis),
    .beat_count(d4_beat),
    .first_mismatch_valid(d4_fmv),
    .first_mismatch_idx(d4_fidx),
    .frame_done(d4_fd)
  );

  int checks = 0;
  int errors = 0;

  logic [DW:0] q1[$];
  logic [DW:0] q2[$];
  int  m_beat, m_mis, m_fidx;
  bit  m_equal, m_fv, m_fd;

  bit a1, a2, r1, r2;

  task automatic model_reset();
    q1.delete();
    q2.delete();
    m_beat = 0; m_mis = 0; m_fidx = 0;
    m_equal = 1; m_fv = 0; m_fd = 0;
  endtask

  // Drive one cycle of stimulus and advance the model across the edge.
  task automatic cycle(
    input bit v1, input logic [DW-1:0] d1, input bit l1,
    input bit v2, input logic [DW-1:0] d2, input bit l2,
    input bit clr,
    output bit acc1, output bit acc2,
    output bit rd1, output bit rd2);
    logic [DW:0] a, b;
    in1_valid = v1; in1_data = d1; in1_last = l1;
    in2_valid = v2; in2_data = d2; in2_last = l2;
    clear = clr;
    #1;
    rd1 = in1_ready;
    rd2 = in2_ready;
    acc1 = v1 && !clr && (q1.size() < DEPTH);
    acc2 = v2 && !clr && (q2.size() < DEPTH);
    @(posedge clk);
    m_fd = 0;
    if (clr) begin
      model_reset();
    end else begin
      if (q1.size() > 0 && q2.size() > 0) begin
        a = q1.pop_front();
        b = q2.pop_front();
        if ((((a[DW:1] ^ b[DW:1]) & mask) != 0) || (a[0] != b[0])) begin
          if (!m_fv) begin
            m_fv = 1;
            m_fidx = m_beat;
          end
          m_mis++;
          m_equal = 0;
        end
        m_beat++;
        m_fd = a[0] | b[0];
      end
      if (acc1) q1.push_back({d1, l1});
      if (acc2) q2.push_back({d2, l2});
    end
    #1;
  endtask

  task automatic idle();
    cycle(0, '0, 0, 0, '0, 0, 0, a1, a2, r1, r2);
  endtask

  task automatic do_clear();
    cycle(0, '0, 0, 0, '0, 0, 1, a1, a2, r1, r2);
    clear = 0;
  endtask

  task automatic test_reset();
    reset = 1; clear = 0; mask = '1;
    in1_valid = 0; in2_valid = 0; in1_last = 0; in2_last = 0;
    in1_data = '0; in2_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in1_ready !== 1'b0 || in2_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready: got %b%b expected 00", in1_ready, in2_ready);
    end
    checks++;
    if (equal !== 1'b1 || mismatch_count !== 16'd0 || beat_count !== 16'd0) begin
      errors++;
      $display("FAIL rst_stats: got eq=%b mis=%0d beat=%0d expected 1/0/0",
               equal, mismatch_count, beat_count);
    end
    checks++;
    if (first_mismatch_valid !== 1'b0 || first_mismatch_idx !== 16'd0 ||
        frame_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_first: got fv=%b idx=%0d fd=%b expected 0/0/0",
               first_mismatch_valid, first_mismatch_idx, frame_done);
    end
    reset = 0;
    #1;
    checks++;
    if (in1_ready !== 1'b1 || in2_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_release_ready: got %b%b expected 11", in1_ready, in2_ready);
    end
  endtask

  task automatic test_identical();
    int pulses = 0;
    do_clear();
    for (int i = 0; i < 11; i++) begin
      if (i < 8) cycle(1, DW'(i), i == 7, 1, DW'(i), i == 7, 0, a1, a2, r1, r2);
      else idle();
      pulses += int'(frame_done);
      checks++;
      if (frame_done !== m_fd) begin
        errors++;
        $display("FAIL v1_fd cyc%0d: got %b expected %b", i, frame_done, m_fd);
      end
    end
    checks++;
    if (beat_count !== 16'd8 || mismatch_count !== 16'd0 || equal !== 1'b1) begin
      errors++;
      $display("FAIL v1_stats: got beat=%0d mis=%0d eq=%b expected 8/0/1",
               beat_count, mismatch_count, equal);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL v1_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_mismatch();
    logic [DW-1:0] x, y;
    do_clear();
    for (int i = 0; i < 11; i++) begin
      x = DW'(i); y = DW'(i);
      if (i == 3) begin x = 32'h00; y = 32'hFF; end
      if (i == 6) begin x = 32'h06; y = 32'h16; end
      if (i < 8) cycle(1, x, i == 7, 1, y, i == 7, 0, a1, a2, r1, r2);
      else idle();
      checks++;
      if (mismatch_count !== 16'(m_mis) || first_mismatch_idx !== 16'(m_fidx)) begin
        errors++;
        $display("FAIL v2_step%0d: got mis=%0d idx=%0d expected %0d/%0d",
                 i, mismatch_count, first_mismatch_idx, m_mis, m_fidx);
      end
    end
    checks++;
    if (equal !== 1'b0 || mismatch_count !== 16'd2 ||
        first_mismatch_idx !== 16'd3 || first_mismatch_valid !== 1'b1) begin
      errors++;
      $display("FAIL v2_final: got eq=%b mis=%0d idx=%0d fv=%b expected 0/2/3/1",
               equal, mismatch_count, first_mismatch_idx, first_mismatch_valid);
    end
  endtask

  task automatic test_mask_last();
    do_clear();
    mask = 32'hFFFFFF00;
    cycle(1, 32'h12345678, 0, 1, 32'h12345600, 0, 0, a1, a2, r1, r2);
    idle();
    checks++;
    if (mismatch_count !== 16'd0 || equal !== 1'b1 || beat_count !== 16'd1) begin
      errors++;
      $display("FAIL v3_mask: got mis=%0d eq=%b beat=%0d expected 0/1/1",
               mismatch_count, equal, beat_count);
    end
    cycle(1, 32'hAA, 1, 1, 32'hAA, 0, 0, a1, a2, r1, r2);
    idle();
    checks++;
    if (mismatch_count !== 16'd1 || equal !== 1'b0 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL v3_last: got mis=%0d eq=%b fd=%b expected 1/0/1",
               mismatch_count, equal, frame_done);
    end
    idle();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL v3_fd_once: got %b expected 0", frame_done);
    end
    mask = '1;
  endtask

  task automatic test_skew();
    int i1 = 0, i2 = 0;
    logic [15:0] prev;
    do_clear();
    for (int k = 0; k < 6; k++) begin
      cycle(1, DW'(100 + i1), 0, 0, '0, 0, 0, a1, a2, r1, r2);
      if (a1) i1++;
      checks++;
      if (in1_ready !== (q1.size() < DEPTH)) begin
        errors++;
        $display("FAIL v4_ready%0d: got %b expected %b", k, in1_ready,
                 q1.size() < DEPTH);
      end
    end
    checks++;
    if (i1 != 4 || in1_ready !== 1'b0) begin
      errors++;
      $display("FAIL v4_full: got beats=%0d ready=%b expected 4/0", i1, in1_ready);
    end
    for (int k = 0; k < 40 && (i1 < 8 || i2 < 8); k++) begin
      cycle(i1 < 8, DW'(100 + i1), i1 == 7, i2 < 8, DW'(100 + i2), i2 == 7,
            0, a1, a2, r1, r2);
      if (a1) i1++;
      if (a2) i2++;
    end
    repeat (6) idle();
    checks++;
    if (beat_count !== 16'd8 || mismatch_count !== 16'd0 || equal !== 1'b1) begin
      errors++;
      $display("FAIL v4_order: got beat=%0d mis=%0d eq=%b expected 8/0/1",
               beat_count, mismatch_count, equal);
    end
    prev = beat_count;
    for (int k = 0; k < 16; k++) begin
      cycle(1, DW'(k), 0, 1, DW'(k), 0, 0, a1, a2, r1, r2);
      if (k >= 1) begin
        checks++;
        if (beat_count !== prev + 16'd1) begin
          errors++;
          $display("FAIL v4_rate%0d: got %0d expected %0d", k, beat_count, prev + 16'd1);
        end
      end
      prev = beat_count;
    end
    repeat (3) idle();
  endtask

  task automatic test_random();
    logic [DW-1:0] s1d[40];
    logic [DW-1:0] s2d[40];
    bit s1l[40];
    bit s2l[40];
    int i1 = 0, i2 = 0;
    do_clear();
    mask = $urandom | 32'h0000_FF00;
    for (int k = 0; k < 40; k++) begin
      s1d[k] = $urandom;
      s2d[k] = ($urandom_range(0, 2) == 0) ?
               (s1d[k] ^ (32'h1 << $urandom_range(0, 31))) : s1d[k];
      s1l[k] = (k % 5) == 4;
      s2l[k] = (k == 17) ? 1'b1 : s1l[k];
    end
    for (int c = 0; c < 300 && (i1 < 40 || i2 < 40 || q1.size() > 0); c++) begin
      cycle((i1 < 40) && ($urandom_range(0, 9) < 7), s1d[i1 % 40], s1l[i1 % 40],
            (i2 < 40) && ($urandom_range(0, 9) < 7), s2d[i2 % 40], s2l[i2 % 40],
            0, a1, a2, r1, r2);
      if (a1) i1++;
      if (a2) i2++;
      checks++;
      if (beat_count !== 16'(m_beat) || mismatch_count !== 16'(m_mis) ||
          equal !== m_equal || first_mismatch_valid !== m_fv ||
          first_mismatch_idx !== 16'(m_fidx) || frame_done !== m_fd ||
          in1_ready !== (q1.size() < DEPTH) || in2_ready !== (q2.size() < DEPTH)) begin
        errors++;
        $display("FAIL rnd_cyc%0d: got b=%0d m=%0d eq=%b fv=%b i=%0d fd=%b rdy=%b%b expected b=%0d m=%0d eq=%b fv=%b i=%0d fd=%b",
                 c, beat_count, mismatch_count, equal, first_mismatch_valid,
                 first_mismatch_idx, frame_done, in1_ready, in2_ready,
                 m_beat, m_mis, m_equal, m_fv, m_fidx, m_fd);
      end
    end
    checks++;
    if (i1 != 40 || i2 != 40 || beat_count !== 16'd40) begin
      errors++;
      $display("FAIL rnd_done: got in1=%0d in2=%0d beat=%0d expected 40/40/40",
               i1, i2, beat_count);
    end
    mask = '1;
  endtask

  task automatic test_saturation();
    do_clear();
    for (int i = 0; i < 24; i++) begin
      if (i < 20) cycle(1, DW'(i), 0, 1, ~DW'(i), 0, 0, a1, a2, r1, r2);
      else idle();
    end
    checks++;
    if (d4_mis !== 4'd15 || d4_beat !== 4'd4) begin
      errors++;
      $display("FAIL v5_cnt4: got mis=%0d beat=%0d expected 15/4", d4_mis, d4_beat);
    end
    checks++;
    if (mismatch_count !== 16'd20 || beat_count !== 16'd20 || equal !== 1'b0) begin
      errors++;
      $display("FAIL v5_cnt16: got mis=%0d beat=%0d eq=%b expected 20/20/0",
               mismatch_count, beat_count, equal);
    end
  endtask

  task automatic test_clear();
    do_clear();
    for (int i = 0; i < 3; i++)
      cycle(1, DW'(i), 0, 1, DW'(i + 50), 0, 0, a1, a2, r1, r2);
    checks++;
    if (beat_count !== 16'd2 || mismatch_count !== 16'd2) begin
      errors++;
      $display("FAIL v6_pre: got beat=%0d mis=%0d expected 2/2", beat_count, mismatch_count);
    end
    cycle(1, 32'h9, 1, 1, 32'h7, 0, 1, a1, a2, r1, r2);
    clear = 0;
    checks++;
    if (r1 !== 1'b0 || r2 !== 1'b0) begin
      errors++;
      $display("FAIL v6_clr_ready: got %b%b expected 00", r1, r2);
    end
    checks++;
    if (beat_count !== 16'd0 || mismatch_count !== 16'd0 || equal !== 1'b1 ||
        first_mismatch_valid !== 1'b0 || first_mismatch_idx !== 16'd0 ||
        frame_done !== 1'b0) begin
      errors++;
      $display("FAIL v6_clr_stats: got b=%0d m=%0d eq=%b fv=%b i=%0d fd=%b expected 0/0/1/0/0/0",
               beat_count, mismatch_count, equal, first_mismatch_valid,
               first_mismatch_idx, frame_done);
    end
    repeat (3) idle();
    checks++;
    if (beat_count !== 16'd0 || in1_ready !== 1'b1) begin
      errors++;
      $display("FAIL v6_clr_flush: got beat=%0d rdy=%b expected 0/1", beat_count, in1_ready);
    end
  endtask

  task automatic test_async_reset();
    do_clear();
    for (int i = 0; i < 3; i++)
      cycle(1, DW'(i), 0, i == 0, DW'(i), 0, 0, a1, a2, r1, r2);
    checks++;
    if (beat_count !== 16'd1) begin
      errors++;
      $display("FAIL v6_ar_pre: got %0d expected 1", beat_count);
    end
    in1_valid = 0; in2_valid = 0;
    #2;
    reset = 1;
    #1;
    checks++;
    if (in1_ready !== 1'b0 || in2_ready !== 1'b0 || beat_count !== 16'd0) begin
      errors++;
      $display("FAIL v6_ar_async: got rdy=%b%b beat=%0d expected 00/0",
               in1_ready, in2_ready, beat_count);
    end
    model_reset();
    #2;
    reset = 0;
    repeat (3) idle();
    checks++;
    if (beat_count !== 16'd0 || mismatch_count !== 16'd0 ||
        in1_ready !== 1'b1 || in2_ready !== 1'b1) begin
      errors++;
      $display("FAIL v6_ar_flush: got beat=%0d mis=%0d rdy=%b%b expected 0/0/11",
               beat_count, mismatch_count, in1_ready, in2_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_identical();
    test_mismatch();
    test_mask_last();
    test_skew();
    test_random();
    test_saturation();
    test_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
